memory_bank_arbiter: RTL and testbench
======================================

MEMORY_BANK_ARBITER -- requirements
Module: memory_bank_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum GRANT cycles (4-bit) before forced release when the other requester is waiting.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  request per requester, bit 0 = requester 0, bit 1 = requester 1; level, held until done.
REQ-005 req_bank0  input  2  bank wanted by requester 0, sampled only at arbitration.
REQ-006 req_bank1  input  2  bank wanted by requester 1, sampled only at arbitration.
REQ-007 gnt  output  2  one-hot grant; at most one bit set.
REQ-008 sel_write_en  output  1  write strobe to memory_bank_selector write_en.
REQ-009 sel_data  output  2  bank value to memory_bank_selector in_data.
REQ-010 cur_bank  output  2  bank the arbiter last wrote to the selector.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 States: IDLE, SWITCH, SETTLE, GRANT; all outputs registered or decoded from registered state only, no combinational path from req to outputs.
REQ-013 IDLE, no req bit set: remain IDLE, gnt = 00, sel_write_en = 0.
REQ-014 IDLE arbitration: single requester wins outright; both set -> requester other than last_owner wins (round robin); winner index and its bank captured as owner/tgt.
REQ-015 IDLE -> GRANT when bank_valid = 1 and tgt == cur_bank; else IDLE -> SWITCH.
REQ-016 SWITCH lasts exactly one cycle: sel_write_en = 1, sel_data = tgt; next SETTLE.
REQ-017 SETTLE lasts exactly one cycle: sel_write_en = 0, cur_bank <= tgt, bank_valid <= 1; next GRANT.
REQ-018 Latency from req sampled at edge N: same bank -> gnt high after edge N; different or invalid bank -> gnt high after edge N+2.
REQ-019 GRANT: gnt[owner] = 1; hold counter increments per cycle, saturating at HOLD_MAX.
REQ-020 GRANT exit on req[owner] = 0: next IDLE, gnt = 00 after that edge, last_owner <= owner.
REQ-021 GRANT forced exit: counter == HOLD_MAX and req[other] = 1 -> IDLE, last_owner <= owner; owner must re-request.
REQ-022 Counter at HOLD_MAX with other requester idle: grant held indefinitely.
REQ-023 Counter cleared on every entry to GRANT.
REQ-024 req_bank change during SWITCH/SETTLE/GRANT ignored; tgt fixed until next arbitration.
REQ-025 req[owner] dropped during SWITCH/SETTLE: sequence still completes to GRANT, then exits to IDLE next cycle per REQ-020 (selector write never aborted).
REQ-026 sel_data holds last written value when sel_write_en = 0.

Reset
REQ-027 rst_n low: state IDLE, gnt 00, sel_write_en 0, sel_data 00, cur_bank 00, bank_valid 0, counter 0, last_owner 1, busy 0, immediately and independent of clk.
REQ-028 bank_valid = 0 after reset forces first grant through SWITCH even for bank 00, since the selector has no reset.
REQ-029 Reset asserted mid SWITCH/SETTLE/GRANT: abort to reset values; no residual strobe after release.

Verification
REQ-030 Reset, req = 01, req_bank0 = 00 -> SWITCH (sel_write_en 1, sel_data 00), SETTLE, gnt = 01 after third edge; selector out_data = 00.
REQ-031 Owner 0 on bank 00 releases, req = 01 with bank 00 again -> gnt = 01 one edge later, sel_write_en never high.
REQ-032 Both req set from IDLE, last_owner 0, req_bank1 = 10 -> requester 1 wins, sel_data 10 strobed, cur_bank = 10, gnt = 10.
REQ-033 Requester 0 holds grant, requester 1 requests, HOLD_MAX = 3 -> gnt drops after 3 GRANT cycles, requester 1 granted next arbitration.
REQ-034 Assert rst_n = 0 during SWITCH -> outputs at reset values before next clk edge; gnt 00, sel_write_en 0.
REQ-035 Change req_bank0 from 01 to 11 during SETTLE -> cur_bank = 01, no second selector write.

Source files
------------

// File: rtl/memory_bank_arbiter.sv
// Two-requester arbiter that owns the memory_bank_selector: picks a winner,
// reprograms the selector bank when needed, then holds a one-hot grant.
// Latency: grant one edge after arbitration on a bank hit, three edges on a
// bank change or on the first grant after reset. No backpressure: requesters
// hold req until done; a waiting requester forces release after HOLD_MAX cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[1:0]            level request per requester
//   req_bank0/1[1:0]    bank wanted by requester 0/1, sampled at arbitration only
//   gnt[1:0]            one-hot grant
//   sel_write_en        write strobe to the selector
//   sel_data[1:0]       bank value presented to the selector
//   cur_bank[1:0]       bank last written to the selector
//   busy                high whenever the arbiter is not idle
module memory_bank_arbiter #(
  parameter logic [3:0] HOLD_MAX = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] req_bank0,
  input  logic [1:0] req_bank1,
  output logic [1:0] gnt,
  output logic       sel_write_en,
  output logic [1:0] sel_data,
  output logic [1:0] cur_bank,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_GRANT  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [1:0] tgt_q, tgt_d;
  logic [1:0] cur_bank_q, cur_bank_d;
  logic       bank_valid_q, bank_valid_d;
  logic [1:0] sel_data_q, sel_data_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;

  logic       win_idx;
  logic [1:0] win_bank;
  logic       other_idx;
  logic [3:0] hold_cnt_inc;
  logic       hold_expired;

  // Arbitration: a lone requester wins; on contention the requester that did
  // not own the bus last time wins.
  always_comb begin
    win_idx = req[1];
    if (req == 2'b11) begin
      win_idx = ~last_owner_q;
    end
    win_bank = win_idx ? req_bank1 : req_bank0;
  end

  assign other_idx    = ~owner_q;
  assign hold_cnt_inc = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : (hold_cnt_q + 4'd1);
  // hold_cnt_inc counts the current grant cycle, so a forced release drops gnt
  // after exactly HOLD_MAX grant cycles.
  assign hold_expired = (hold_cnt_inc == HOLD_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tgt_q        <= 2'b00;
      cur_bank_q   <= 2'b00;
      bank_valid_q <= 1'b0;
      sel_data_q   <= 2'b00;
      hold_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tgt_q        <= tgt_d;
      cur_bank_q   <= cur_bank_d;
      bank_valid_q <= bank_valid_d;
      sel_data_q   <= sel_data_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tgt_d        = tgt_q;
    cur_bank_d   = cur_bank_q;
    bank_valid_d = bank_valid_q;
    sel_data_d   = sel_data_q;
    hold_cnt_d   = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          owner_d = win_idx;
          tgt_d   = win_bank;
          // The selector has no reset, so its bank is trusted only after we
          // have written it at least once.
          if (bank_valid_q && (win_bank == cur_bank_q)) begin
            state_d    = ST_GRANT;
            hold_cnt_d = 4'd0;
          end else begin
            state_d    = ST_SWITCH;
            sel_data_d = win_bank;
          end
        end
      end
      ST_SWITCH: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d      = ST_GRANT;
        cur_bank_d   = tgt_q;
        bank_valid_d = 1'b1;
        hold_cnt_d   = 4'd0;
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_inc;
        if (!req[owner_q] || (hold_expired && req[other_idx])) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    gnt          = 2'b00;
    sel_write_en = (state_q == ST_SWITCH);
    busy         = (state_q != ST_IDLE);
    if (state_q == ST_GRANT) begin
      gnt = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign sel_data = sel_data_q;
  assign cur_bank = cur_bank_q;

endmodule

// File: tb/tb_memory_bank_arbiter.sv
// Testbench for memory_bank_arbiter: directed scenarios followed by random
// request/bank traffic with occasional asynchronous resets, all checked
// cycle by cycle against a transaction-level reference model.
module tb_memory_bank_arbiter;

  localparam int HOLD = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] req_bank0;
  logic [1:0] req_bank1;
  logic [1:0] gnt;
  logic       sel_write_en;
  logic [1:0] sel_data;
  logic [1:0] cur_bank;
  logic       busy;

  int n_vec;
  int n_miss;

  memory_bank_arbiter #(
    .HOLD_MAX(4'd3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_bank0   (req_bank0),
    .req_bank1   (req_bank1),
    .gnt         (gnt),
    .sel_write_en(sel_write_en),
    .sel_data    (sel_data),
    .cur_bank    (cur_bank),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one arbitration "session" at a time.
  // m_wait = setup cycles still to go before the grant (2 = strobe cycle).
  // m_held = grant cycles completed in this session.
  bit         m_busy;
  int         m_wait;
  int         m_held;
  int         m_owner;
  int         m_last;
  logic [1:0] m_tgt;
  logic [1:0] m_cur;
  bit         m_valid;
  logic [1:0] m_seldata;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_wait    = 0;
    m_held    = 0;
    m_owner   = 0;
    m_last    = 1;
    m_tgt     = 2'b00;
    m_cur     = 2'b00;
    m_valid   = 1'b0;
    m_seldata = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [1:0] b0, input logic [1:0] b1);
    int         w;
    logic [1:0] bk;
    if (!m_busy) begin
      if (r != 2'b00) begin
        if (r == 2'b11)      w = 1 - m_last;
        else if (r == 2'b01) w = 0;
        else                 w = 1;
        bk      = (w == 0) ? b0 : b1;
        m_owner = w;
        m_tgt   = bk;
        m_busy  = 1'b1;
        m_held  = 0;
        if (m_valid && (bk == m_cur)) begin
          m_wait = 0;
        end else begin
          m_wait    = 2;
          m_seldata = bk;
        end
      end
    end else if (m_wait > 0) begin
      if (m_wait == 1) begin
        m_cur   = m_tgt;
        m_valid = 1'b1;
      end
      m_wait--;
    end else begin
      m_held++;
      if ((r[m_owner] == 1'b0) || ((m_held >= HOLD) && (r[1 - m_owner] == 1'b1))) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    eg = 2'b00;
    if (m_busy && (m_wait == 0)) eg = (m_owner == 1) ? 2'b10 : 2'b01;
    check_eq("gnt",          {2'b00, gnt},          {2'b00, eg});
    check_eq("sel_write_en", {3'b000, sel_write_en}, {3'b000, (m_busy && (m_wait == 2))});
    check_eq("sel_data",     {2'b00, sel_data},     {2'b00, m_seldata});
    check_eq("cur_bank",     {2'b00, cur_bank},     {2'b00, m_cur});
    check_eq("busy",         {3'b000, busy},        {3'b000, m_busy});
  endtask

  // Apply inputs (called just after a falling edge), clock once, update the
  // model and compare on the following falling edge.
  task automatic tick(input logic [1:0] r, input logic [1:0] b0, input logic [1:0] b1);
    req       = r;
    req_bank0 = b0;
    req_bank1 = b1;
    @(posedge clk);
    model_step(r, b0, b1);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    req = 2'b00;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] b0;
    logic [1:0] b1;
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    req       = 2'b00;
    req_bank0 = 2'b00;
    req_bank1 = 2'b00;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // First grant after reset goes through the selector even for bank 00.
    tick(2'b01, 2'b00, 2'b00);
    check_eq("first_strobe", {3'b000, sel_write_en}, 4'h1);
    tick(2'b01, 2'b00, 2'b00);
    tick(2'b01, 2'b00, 2'b00);
    check_eq("first_gnt", {2'b00, gnt}, 4'h1);

    // Release, then same bank again: direct grant with no strobe.
    tick(2'b00, 2'b00, 2'b00);
    tick(2'b01, 2'b00, 2'b00);
    check_eq("hit_gnt", {2'b00, gnt}, 4'h1);
    check_eq("hit_nostrobe", {3'b000, sel_write_en}, 4'h0);
    tick(2'b00, 2'b00, 2'b00);

    // Contention after owner 0: requester 1 wins and switches to bank 10.
    tick(2'b11, 2'b00, 2'b10);
    check_eq("rr_seldata", {2'b00, sel_data}, 4'h2);
    tick(2'b11, 2'b00, 2'b10);
    tick(2'b11, 2'b00, 2'b10);
    check_eq("rr_gnt", {2'b00, gnt}, 4'h2);
    check_eq("rr_cur", {2'b00, cur_bank}, 4'h2);

    // Forced release after HOLD grant cycles while requester 0 waits.
    tick(2'b11, 2'b00, 2'b10);
    tick(2'b11, 2'b00, 2'b10);
    check_eq("hold_still", {2'b00, gnt}, 4'h2);
    tick(2'b11, 2'b00, 2'b10);
    check_eq("hold_drop", {2'b00, gnt}, 4'h0);

    // Requester 0 wins next; its bank changes during the switch sequence.
    tick(2'b11, 2'b01, 2'b10);
    check_eq("sw_seldata", {2'b00, sel_data}, 4'h1);
    tick(2'b11, 2'b11, 2'b10);
    tick(2'b11, 2'b11, 2'b10);
    check_eq("ign_cur", {2'b00, cur_bank}, 4'h1);
    check_eq("ign_gnt", {2'b00, gnt}, 4'h1);
    check_eq("ign_nostrobe", {3'b000, sel_write_en}, 4'h0);
    tick(2'b00, 2'b11, 2'b10);

    // Reset while strobing the selector.
    tick(2'b01, 2'b11, 2'b00);
    check_eq("pre_rst_strobe", {3'b000, sel_write_en}, 4'h1);
    do_reset();
    check_eq("rst_gnt", {2'b00, gnt}, 4'h0);
    check_eq("rst_strobe", {3'b000, sel_write_en}, 4'h0);
    tick(2'b00, 2'b00, 2'b00);
    tick(2'b00, 2'b00, 2'b00);

    // Random traffic: sticky request levels, drifting banks, rare resets.
    r  = 2'b00;
    b0 = 2'b00;
    b1 = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
      end
      if ($urandom_range(0, 2) == 0) b0 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) b1 = 2'($urandom_range(0, 3));
      tick(r, b0, b1);
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
